mesi_snoop_responder: RTL and testbench
=======================================

# mesi_snoop_responder

Bus-side snoop agent for the L1 data cache. It accepts snoop operations issued by other bus masters and looks up the local line's MESI state in the tag/state array. It returns the snoop result (HIT/HITM/NOHIT), runs a writeback handshake when a modified line is snooped, and writes back the next MESI state. It is the bus-facing counterpart to the per-line processor-side MESI state machine and shares that machine's state encoding: I=2'b00, S=2'b01, E=2'b10, M=2'b11.

## Interface
- INDEX_W, 14: width of cache set/line index.
- CNT_W, 16: width of the HITM event counter.

- clk  input  1  single clock; all logic on posedge.
- reset  input  1  synchronous, active-high; sampled on posedge clk.
- snoop_valid  input  1  snoop request present.
- snoop_ready  output  1  responder idle, can accept.
- snoop_op  input  2  00=READ, 01=RWIM, 10=INVALIDATE, 11=WRITE.
- snoop_index  input  INDEX_W  line index of snooped address.
- state_rd_index  output  INDEX_W  state-array read index.
- state_rd_data  input  2  MESI state, valid one cycle after index.
- state_wr_en  output  1  one-cycle state-array write strobe.
- state_wr_index  output  INDEX_W  write index.
- state_wr_data  output  2  next MESI state.
- result_valid  output  1  one-cycle strobe: snoop_result valid.
- snoop_result  output  2  00=HIT, 01=HITM, 10=NOHIT.
- wb_req  output  1  writeback of modified line requested.
- wb_ack  input  1  writeback complete.
- wb_index  output  INDEX_W  line being written back.
- hitm_count  output  CNT_W  saturating count of HITM responses.
- proto_err  output  1  one-cycle protocol-error strobe (see Configuration).

## Operation
- FSM states: IDLE, LOOKUP, RESPOND, WRITEBACK.
- IDLE: snoop_ready=1. When snoop_valid&snoop_ready, capture snoop_op and snoop_index, then go to LOOKUP.
- LOOKUP: state_rd_index = captured index; go to RESPOND.
- RESPOND: sample state_rd_data, pulse result_valid, and compute result and next state:
  - READ: M→HITM, next S, writeback; E/S→HIT, next S; I→NOHIT, no change.
  - RWIM: M→HITM, next I, writeback; E/S→HIT, next I; I→NOHIT.
  - INVALIDATE: S→HIT, next I; E/M→HIT, next I, no writeback, protocol error; I→NOHIT.
  - WRITE: NOHIT, no state change; if line is M or E, protocol error.
- No writeback: state_wr_en pulses in RESPOND (skipped when there is no state change); return to IDLE.
- Writeback: go to WRITEBACK; wb_req=1 and wb_index=captured index, held until wb_ack=1. In the ack cycle, state_wr_en pulses with the next state; wb_req=0 from the following cycle; return to IDLE.
- wb_ack is ignored outside WRITEBACK.
- hitm_count increments in each RESPOND cycle that reports HITM and saturates at all-ones.
- state_wr_index always equals the captured index.

## Timing
- Reset values: snoop_ready=0 during the reset cycle and 1 afterwards. result_valid, state_wr_en, wb_req, and proto_err are 0. snoop_result=NOHIT, hitm_count=0, and all index outputs are 0.
- Accept at cycle T, LOOKUP at T+1, RESPOND at T+2 (result_valid, and state_wr_en if applicable). IDLE at T+3, with the next accept possible at T+3.
- HITM path: wb_req rises at T+3. If wb_ack arrives at cycle A, state_wr_en pulses at A, IDLE is entered at A+1, and the next accept is possible at A+1. The minimum is wb_ack at T+3, giving IDLE at T+4.
- snoop_ready=0 in every state except IDLE. A snoop_valid arriving then is held by the bus and is not dropped by this block.
- Reset asserted mid-operation: the next cycle is IDLE, wb_req drops, and no state write or result is issued. The in-flight snoop is discarded and hitm_count clears.
- snoop_result holds its last value between result_valid strobes.

## Configuration
- SNOOP_PROTO_CHECK_EN defined: proto_err pulses in the RESPOND cycle for INVALIDATE on E/M, and for WRITE on E/M.
- SNOOP_PROTO_CHECK_EN undefined: proto_err is tied to 0 and the checking logic is absent. State transitions and results are identical in both builds.

## Test plan
- Reset, then READ on index 5 with array state S → result HIT at T+2, state_wr_en not asserted, snoop_ready high at T+3.
- READ on index 7 with state M, wb_ack delayed 3 cycles → HITM at T+2, wb_req high T+3..T+5 with wb_index=7, state_wr_data=S at T+5 ack cycle, hitm_count=1.
- RWIM on index 9 with state E → HIT, state_wr_data=I at T+2; RWIM with state I → NOHIT and no write.
- INVALIDATE with state M → HIT, next state I, wb_req never asserted, proto_err=1 only when SNOOP_PROTO_CHECK_EN is defined.
- Reset asserted while wb_req is high → wb_req=0 the next cycle, no state_wr_en, snoop_ready=1 one cycle after reset deasserts.
- With hitm_count preloaded by 2^CNT_W HITM snoops → count stays at all-ones.

Source files
------------

// File: rtl/mesi_snoop_responder.sv
// mesi_snoop_responder: bus-side MESI snoop agent for the L1 data cache.
// Looks up the snooped line's state, reports HIT/HITM/NOHIT, runs the
// writeback handshake for modified lines and writes the next MESI state.
// Optional build macro: SNOOP_PROTO_CHECK_EN enables the proto_err strobe.
module mesi_snoop_responder #(
  parameter int unsigned INDEX_W = 14,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               snoop_valid,
  output logic               snoop_ready,
  input  logic [1:0]         snoop_op,
  input  logic [INDEX_W-1:0] snoop_index,
  output logic [INDEX_W-1:0] state_rd_index,
  input  logic [1:0]         state_rd_data,
  output logic               state_wr_en,
  output logic [INDEX_W-1:0] state_wr_index,
  output logic [1:0]         state_wr_data,
  output logic               result_valid,
  output logic [1:0]         snoop_result,
  output logic               wb_req,
  input  logic               wb_ack,
  output logic [INDEX_W-1:0] wb_index,
  output logic [CNT_W-1:0]   hitm_count,
  output logic               proto_err
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LOOKUP    = 2'd1,
    ST_RESPOND   = 2'd2,
    ST_WRITEBACK = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    MESI_I = 2'b00,
    MESI_S = 2'b01,
    MESI_E = 2'b10,
    MESI_M = 2'b11
  } mesi_e;

  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_RWIM  = 2'b01,
    OP_INV   = 2'b10,
    OP_WRITE = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    RES_HIT   = 2'b00,
    RES_HITM  = 2'b01,
    RES_NOHIT = 2'b10
  } res_e;

  state_e             state_q, state_d;
  op_e                op_q;
  logic [INDEX_W-1:0] idx_q;
  mesi_e              nxt_q;
  res_e               res_q;
  logic [CNT_W-1:0]   cnt_q;

  mesi_e cur;
  res_e  lk_res;
  mesi_e lk_nxt;
  logic  lk_wb;

  assign cur = mesi_e'(state_rd_data);

  // Snoop decode: result, next state and writeback need for the looked-up line
  always_comb begin
    lk_res = RES_NOHIT;
    lk_nxt = cur;
    lk_wb  = 1'b0;
    unique case (op_q)
      OP_READ: begin
        unique case (cur)
          MESI_M:         begin lk_res = RES_HITM; lk_nxt = MESI_S; lk_wb = 1'b1; end
          MESI_E, MESI_S: begin lk_res = RES_HIT;  lk_nxt = MESI_S; end
          default:        ;
        endcase
      end
      OP_RWIM: begin
        unique case (cur)
          MESI_M:         begin lk_res = RES_HITM; lk_nxt = MESI_I; lk_wb = 1'b1; end
          MESI_E, MESI_S: begin lk_res = RES_HIT;  lk_nxt = MESI_I; end
          default:        ;
        endcase
      end
      OP_INV: begin
        if (cur != MESI_I) begin
          lk_res = RES_HIT;
          lk_nxt = MESI_I;
        end
      end
      default: ;
    endcase
  end

  // Next-state and output decode; reset suppresses every strobe in its cycle
  always_comb begin
    state_d       = state_q;
    snoop_ready   = 1'b0;
    result_valid  = 1'b0;
    state_wr_en   = 1'b0;
    state_wr_data = nxt_q;
    wb_req        = 1'b0;
    snoop_result  = res_q;
    unique case (state_q)
      ST_IDLE: begin
        snoop_ready = 1'b1;
        if (snoop_valid) state_d = ST_LOOKUP;
      end
      ST_LOOKUP: state_d = ST_RESPOND;
      ST_RESPOND: begin
        result_valid  = 1'b1;
        snoop_result  = lk_res;
        state_wr_data = lk_nxt;
        if (lk_wb) begin
          state_d = ST_WRITEBACK;
        end else begin
          state_wr_en = (lk_nxt != cur);
          state_d     = ST_IDLE;
        end
      end
      ST_WRITEBACK: begin
        wb_req = 1'b1;
        if (wb_ack) begin
          state_wr_en = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (reset) begin
      snoop_ready  = 1'b0;
      result_valid = 1'b0;
      state_wr_en  = 1'b0;
      wb_req       = 1'b0;
      snoop_result = RES_NOHIT;
    end
  end

  // State register, snoop capture, held result and saturating HITM counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      op_q    <= OP_READ;
      idx_q   <= '0;
      nxt_q   <= MESI_I;
      res_q   <= RES_NOHIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && snoop_valid) begin
        op_q  <= op_e'(snoop_op);
        idx_q <= snoop_index;
      end
      if (state_q == ST_RESPOND) begin
        res_q <= lk_res;
        nxt_q <= lk_nxt;
        if (lk_res == RES_HITM && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign state_rd_index = idx_q;
  assign state_wr_index = idx_q;
  assign wb_index       = idx_q;
  assign hitm_count     = cnt_q;

`ifdef SNOOP_PROTO_CHECK_EN
  logic lk_proto;

  // INVALIDATE or WRITE snooping an exclusively owned line is a bus protocol violation
  always_comb begin
    lk_proto = (op_q == OP_INV || op_q == OP_WRITE) && (cur == MESI_E || cur == MESI_M);
  end

  assign proto_err = (state_q == ST_RESPOND) && lk_proto && !reset;
`else
  assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_mesi_snoop_responder.sv
// Directed table-driven bench for mesi_snoop_responder with a behavioural state array.
module tb_mesi_snoop_responder;
  localparam int IW = 14;
  localparam int CW = 4;
`ifdef SNOOP_PROTO_CHECK_EN
  localparam bit PROTO_EN = 1'b1;
`else
  localparam bit PROTO_EN = 1'b0;
`endif

  localparam logic [1:0] I = 2'b00, S = 2'b01, E = 2'b10, M = 2'b11;
  localparam logic [1:0] RD = 2'b00, RW = 2'b01, INV = 2'b10, WR = 2'b11;
  localparam logic [1:0] HIT = 2'b00, HITM = 2'b01, NOH = 2'b10;

  logic          clk, reset, snoop_valid, snoop_ready, state_wr_en, result_valid;
  logic          wb_req, wb_ack, proto_err;
  logic [1:0]    snoop_op, state_rd_data, state_wr_data, snoop_result;
  logic [IW-1:0] snoop_index, state_rd_index, state_wr_index, wb_index;
  logic [CW-1:0] hitm_count;

  mesi_snoop_responder #(.INDEX_W(IW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .snoop_valid(snoop_valid), .snoop_ready(snoop_ready),
    .snoop_op(snoop_op), .snoop_index(snoop_index), .state_rd_index(state_rd_index),
    .state_rd_data(state_rd_data), .state_wr_en(state_wr_en), .state_wr_index(state_wr_index),
    .state_wr_data(state_wr_data), .result_valid(result_valid), .snoop_result(snoop_result),
    .wb_req(wb_req), .wb_ack(wb_ack), .wb_index(wb_index), .hitm_count(hitm_count),
    .proto_err(proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // State array model: one-cycle read latency, bench preload has priority over DUT writes
  logic [1:0]    mem [0:(1<<IW)-1];
  logic          pre_en;
  logic [IW-1:0] pre_idx;
  logic [1:0]    pre_val;
  always @(posedge clk) begin
    if (pre_en) mem[pre_idx] <= pre_val;
    else if (state_wr_en) mem[state_wr_index] <= state_wr_data;
    state_rd_data <= mem[state_rd_index];
  end

  int nvec = 0;
  int nerr = 0;
  int exp_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]    op;
    logic [IW-1:0] idx;
    logic [1:0]    init;
    int            ack_at;
    logic [1:0]    res;
    bit            wr;
    logic [1:0]    nxt;
    bit            wb;
    bit            proto;
  } vec_t;

  task automatic preload(input logic [IW-1:0] idx, input logic [1:0] val);
    pre_en = 1'b1; pre_idx = idx; pre_val = val;
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  task automatic run(input vec_t v);
    preload(v.idx, v.init);
    // cycle T: accept
    snoop_valid = 1'b1; snoop_op = v.op; snoop_index = v.idx;
    #1;
    chk("ready_T", 32'(snoop_ready), 32'(1));
    @(negedge clk);
    snoop_valid = 1'b0;
    // T+1: LOOKUP
    chk("ready_busy", 32'(snoop_ready), 32'(0));
    chk("rd_index", 32'(state_rd_index), 32'(v.idx));
    @(negedge clk);
    // T+2: RESPOND
    chk("result_valid", 32'(result_valid), 32'(1));
    chk("snoop_result", 32'(snoop_result), 32'(v.res));
    chk("proto_err", 32'(proto_err), 32'(v.proto & PROTO_EN));
    chk("wr_en_respond", 32'(state_wr_en), 32'(v.wr && !v.wb));
    if (v.wr && !v.wb) begin
      chk("wr_data_respond", 32'(state_wr_data), 32'(v.nxt));
      chk("wr_index", 32'(state_wr_index), 32'(v.idx));
    end
    if (v.res == HITM && exp_cnt != (1 << CW) - 1) exp_cnt++;
    if (!v.wb) begin
      @(negedge clk);
      chk("ready_T3", 32'(snoop_ready), 32'(1));
      chk("result_valid_T3", 32'(result_valid), 32'(0));
      chk("result_hold", 32'(snoop_result), 32'(v.res));
      chk("wb_req_none", 32'(wb_req), 32'(0));
    end else begin
      for (int c = 3; c < v.ack_at; c++) begin
        @(negedge clk);
        chk("wb_req_wait", 32'(wb_req), 32'(1));
        chk("wb_index", 32'(wb_index), 32'(v.idx));
        chk("wr_en_wait", 32'(state_wr_en), 32'(0));
      end
      @(negedge clk);
      wb_ack = 1'b1;
      #1;
      chk("wb_req_ack", 32'(wb_req), 32'(1));
      chk("wr_en_ack", 32'(state_wr_en), 32'(1));
      chk("wr_data_ack", 32'(state_wr_data), 32'(v.nxt));
      chk("ready_ack", 32'(snoop_ready), 32'(0));
      @(negedge clk);
      wb_ack = 1'b0;
      #1;
      chk("wb_req_drop", 32'(wb_req), 32'(0));
      chk("ready_after_wb", 32'(snoop_ready), 32'(1));
    end
    chk("array_state", 32'(mem[v.idx]), 32'(v.nxt));
    chk("hitm_count", 32'(hitm_count), 32'(exp_cnt));
  endtask

  vec_t vt [15];
  vec_t sv;

  initial begin
    vt[0]  = '{RD,  14'd5,     S, 0, HIT,  1'b0, S, 1'b0, 1'b0};
    vt[1]  = '{RD,  14'd7,     M, 5, HITM, 1'b1, S, 1'b1, 1'b0};
    vt[2]  = '{RW,  14'd9,     E, 0, HIT,  1'b1, I, 1'b0, 1'b0};
    vt[3]  = '{RW,  14'd9,     I, 0, NOH,  1'b0, I, 1'b0, 1'b0};
    vt[4]  = '{INV, 14'd11,    M, 0, HIT,  1'b1, I, 1'b0, 1'b1};
    vt[5]  = '{INV, 14'd12,    S, 0, HIT,  1'b1, I, 1'b0, 1'b0};
    vt[6]  = '{INV, 14'd13,    I, 0, NOH,  1'b0, I, 1'b0, 1'b0};
    vt[7]  = '{WR,  14'd14,    E, 0, NOH,  1'b0, E, 1'b0, 1'b1};
    vt[8]  = '{WR,  14'd15,    S, 0, NOH,  1'b0, S, 1'b0, 1'b0};
    vt[9]  = '{RD,  14'd16,    E, 0, HIT,  1'b1, S, 1'b0, 1'b0};
    vt[10] = '{RW,  14'h3FFF,  M, 3, HITM, 1'b1, I, 1'b1, 1'b0};
    vt[11] = '{RD,  14'd17,    I, 0, NOH,  1'b0, I, 1'b0, 1'b0};
    vt[12] = '{INV, 14'd18,    E, 0, HIT,  1'b1, I, 1'b0, 1'b1};
    vt[13] = '{WR,  14'd19,    M, 0, NOH,  1'b0, M, 1'b0, 1'b1};
    vt[14] = '{RW,  14'd21,    S, 0, HIT,  1'b1, I, 1'b0, 1'b0};

    reset = 1'b1; snoop_valid = 1'b0; snoop_op = '0; snoop_index = '0;
    wb_ack = 1'b0; pre_en = 1'b0; pre_idx = '0; pre_val = '0;
    @(negedge clk);
    @(negedge clk);
    chk("ready_in_reset", 32'(snoop_ready), 32'(0));
    reset = 1'b0;
    #1;
    chk("rst_ready", 32'(snoop_ready), 32'(1));
    chk("rst_result_valid", 32'(result_valid), 32'(0));
    chk("rst_wr_en", 32'(state_wr_en), 32'(0));
    chk("rst_wb_req", 32'(wb_req), 32'(0));
    chk("rst_proto_err", 32'(proto_err), 32'(0));
    chk("rst_result", 32'(snoop_result), 32'(NOH));
    chk("rst_hitm", 32'(hitm_count), 32'(0));
    chk("rst_rd_index", 32'(state_rd_index), 32'(0));
    chk("rst_wr_index", 32'(state_wr_index), 32'(0));
    chk("rst_wb_index", 32'(wb_index), 32'(0));

    for (int i = 0; i < 15; i++) run(vt[i]);

    // Counter saturation: more HITM snoops than the counter can represent
    for (int i = 0; i < (1 << CW); i++) begin
      sv = '{RD, 14'(100 + i), M, 3, HITM, 1'b1, S, 1'b1, 1'b0};
      run(sv);
    end
    chk("hitm_saturated", 32'(hitm_count), 32'((1 << CW) - 1));

    // Reset while a writeback is pending, with wb_ack coinciding with reset
    preload(14'd20, M);
    snoop_valid = 1'b1; snoop_op = RD; snoop_index = 14'd20;
    @(negedge clk);
    snoop_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_wb_req", 32'(wb_req), 32'(1));
    reset = 1'b1; wb_ack = 1'b1;
    #1;
    chk("rst_mid_wr_en", 32'(state_wr_en), 32'(0));
    chk("rst_mid_ready", 32'(snoop_ready), 32'(0));
    @(negedge clk);
    reset = 1'b0; wb_ack = 1'b0;
    exp_cnt = 0;
    #1;
    chk("rst_mid_wb_req", 32'(wb_req), 32'(0));
    chk("rst_mid_wr_en2", 32'(state_wr_en), 32'(0));
    chk("rst_mid_ready2", 32'(snoop_ready), 32'(1));
    chk("rst_mid_hitm", 32'(hitm_count), 32'(exp_cnt));
    @(negedge clk);
    chk("rst_mid_ready3", 32'(snoop_ready), 32'(1));
    chk("rst_mid_result_valid", 32'(result_valid), 32'(0));
    chk("rst_mid_array", 32'(mem[20]), 32'(M));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d miscompares so far", nerr);
    $fatal(1);
  end
endmodule
